mips_cpu_fetch: RTL and testbench

Instruction fetch and program-counter stage of the multicycle MIPS CPU. It holds the PC and issues instruction reads on the memory bus. It presents each fetched word to the control decoder for one execute cycle. It then applies the decoder's `CtrlPC` selection, including MIPS branch-delay-slot ordering. It also raises the halt condition when control transfers to address 0.

---
 rtl/mips_cpu_fetch.sv | 134 +++++++++++++
 tb/tb_mips_cpu_fetch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_fetch.sv
// Multicycle MIPS fetch/PC stage: FETCH/EXEC sequencing,
// delay-slot redirect and halt on a jump to address zero.
module mips_cpu_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  CtrlPC,
  input  logic [31:0] RegJumpTarget,
  input  logic        Stall,
  input  logic [31:0] imem_readdata,
  input  logic        imem_waitrequest,
  output logic [31:0] imem_address,
  output logic        imem_read,
  output logic [31:0] Instr,
  output logic        InstrValid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus8,
  output logic        Active
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] instr, instr_nxt;
  logic [31:0] pend_target, pend_target_nxt;
  logic        pend_valid, pend_valid_nxt;

  logic [31:0] pc4;
  logic [31:0] br_tgt;
  logic [31:0] j_tgt;
  logic [31:0] r_tgt;
  logic [31:0] tgt;
  logic [31:0] npc;
  logic        npend_valid;
  logic [31:0] npend_target;

  assign pc4    = pc + 32'd4;
  assign br_tgt = pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
  assign j_tgt  = {pc4[31:28], instr[25:0], 2'b00};
  assign r_tgt  = {RegJumpTarget[31:2], 2'b00};

  always_comb begin
    tgt = pc4;
    unique case (CtrlPC)
      2'd1:    tgt = br_tgt;
      2'd2:    tgt = j_tgt;
      2'd3:    tgt = r_tgt;
      default: tgt = pc4;
    endcase
  end

  // A transfer first fetches the delay slot; the target is
  // parked until the slot leaves EXEC.
  always_comb begin
    npc          = pc4;
    npend_valid  = pend_valid;
    npend_target = pend_target;
    unique case (1'b1)
      pend_valid: begin
        npc         = pend_target;
        npend_valid = 1'b0;
      end
      (!pend_valid && CtrlPC != 2'd0): begin
        npc          = pc4;
        npend_valid  = 1'b1;
        npend_target = tgt;
      end
      default: begin
        npc = pc4;
      end
    endcase
  end

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    instr_nxt       = instr;
    pend_valid_nxt  = pend_valid;
    pend_target_nxt = pend_target;
    case (state)
      FETCH: begin
        if (!imem_waitrequest) begin
          instr_nxt = imem_readdata;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (!Stall) begin
          pc_nxt          = npc;
          pend_valid_nxt  = npend_valid;
          pend_target_nxt = npend_target;
          state_nxt       = (npc == 32'd0) ? HALTED : FETCH;
        end
      end
      HALTED: begin
        pc_nxt = 32'd0;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_VECTOR;
      instr       <= 32'd0;
      pend_valid  <= 1'b0;
      pend_target <= 32'd0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      instr       <= instr_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_target <= pend_target_nxt;
    end
  end

  assign imem_address = pc;
  assign imem_read    = rst_n && (state == FETCH);
  assign Instr        = instr;
  assign InstrValid   = (state == EXEC);
  assign PC           = pc;
  assign PCPlus8      = pc + 32'd8;
  assign Active       = (state != HALTED);

endmodule

// File: tb/tb_mips_cpu_fetch.sv
// Directed bench for mips_cpu_fetch with a tiny ROM
// and an inline decoder producing CtrlPC.
module tb_mips_cpu_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  CtrlPC;
  logic [31:0] RegJumpTarget = 32'd0;
  logic        Stall = 1'b0;
  logic [31:0] imem_readdata;
  logic        imem_waitrequest = 1'b0;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] Instr;
  logic        InstrValid;
  logic [31:0] PC;
  logic [31:0] PCPlus8;
  logic        Active;

  int tests = 0;
  int failed = 0;
  int prog = 0;
  logic [31:0] fetched[$];

  mips_cpu_fetch dut (
    .clk(clk),
    .rst_n(rst_n),
    .CtrlPC(CtrlPC),
    .RegJumpTarget(RegJumpTarget),
    .Stall(Stall),
    .imem_readdata(imem_readdata),
    .imem_waitrequest(imem_waitrequest),
    .imem_address(imem_address),
    .imem_read(imem_read),
    .Instr(Instr),
    .InstrValid(InstrValid),
    .PC(PC),
    .PCPlus8(PCPlus8),
    .Active(Active)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input int p, input logic [31:0] a);
    rom = 32'd0;
    if (p == 1 && a == 32'hBFC00010) rom = 32'h1000FFFC;
    if (p == 2 && a == 32'hBFC00020) rom = 32'h0BF00100;
    if (p == 2 && a == 32'hBFC00024) rom = 32'h00851021;
    if (p == 3 && a == 32'hBFC00008) rom = 32'h03E00008;
  endfunction

  function automatic logic [1:0] dec(input logic [31:0] i);
    dec = 2'd0;
    if (i[31:26] == 6'd4) dec = 2'd1;
    if (i[31:26] == 6'd2) dec = 2'd2;
    if (i[31:26] == 6'd0 && i[5:0] == 6'h08) dec = 2'd3;
  endfunction

  assign imem_readdata = rom(prog, imem_address);
  assign CtrlPC = InstrValid ? dec(Instr) : 2'd0;

  always @(negedge clk)
    if (rst_n && imem_read && !imem_waitrequest)
      fetched.push_back(imem_address);

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    Stall = 1'b0;
    imem_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    fetched.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_fetches(input int n, input int budget);
    int c = 0;
    while (fetched.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    tests++;
    if (fetched.size() < n) begin
      failed++;
      $display("FAIL fetch_timeout: got %0d fetches want %0d",
               fetched.size(), n);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    prog = 0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_read", {31'd0, imem_read}, 32'd0);
    chk("rst_valid", {31'd0, InstrValid}, 32'd0);
    chk("rst_active", {31'd0, Active}, 32'd1);
    chk("rst_instr", Instr, 32'd0);
    chk("rst_pc", PC, 32'hBFC00000);
    chk("rst_pc8", PCPlus8, 32'hBFC00008);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_read", {31'd0, imem_read}, 32'd1);
  endtask

  task automatic test_sequential();
    logic [31:0] a;
    prog = 0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      a = 32'hBFC00000 + 32'(4 * (k / 2));
      chk("seq_valid", {31'd0, InstrValid}, 32'(k % 2));
      chk("seq_read", {31'd0, imem_read}, 32'((k + 1) % 2));
      if (k % 2 == 0) chk("seq_addr", imem_address, a);
      else chk("seq_pc8", PCPlus8, a + 32'd8);
    end
  endtask

  task automatic test_waitrequest();
    prog = 0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    Stall = 1'b0;
    imem_waitrequest = 1'b1;
    @(posedge clk); #1;
    fetched.delete();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("wait_addr", imem_address, 32'hBFC00000);
      chk("wait_read", {31'd0, imem_read}, 32'd1);
      chk("wait_valid", {31'd0, InstrValid}, 32'd0);
      if (k == 2) begin
        @(posedge clk); #1;
        imem_waitrequest = 1'b0;
      end
    end
    @(negedge clk);
    chk("wait_exec", {31'd0, InstrValid}, 32'd1);
    chk("wait_once", 32'(fetched.size()), 32'd1);
  endtask

  task automatic test_branch();
    prog = 1;
    do_reset();
    wait_fetches(8, 40);
    if (fetched.size() >= 8) begin
      chk("beq_at", fetched[4], 32'hBFC00010);
      chk("beq_slot", fetched[5], 32'hBFC00014);
      chk("beq_tgt", fetched[6], 32'hBFC00004);
      chk("beq_next", fetched[7], 32'hBFC00008);
    end
  endtask

  task automatic test_jump();
    prog = 2;
    do_reset();
    wait_fetches(11, 50);
    if (fetched.size() >= 11) begin
      chk("j_at", fetched[8], 32'hBFC00020);
      chk("j_slot", fetched[9], 32'hBFC00024);
      chk("j_tgt", fetched[10], 32'hBFC00400);
    end
  endtask

  task automatic test_halt();
    int c = 0;
    prog = 3;
    RegJumpTarget = 32'h00000003;
    do_reset();
    while (Active && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("halt_active", {31'd0, Active}, 32'd0);
    chk("halt_nfetch", 32'(fetched.size()), 32'd4);
    if (fetched.size() >= 4) chk("halt_slot", fetched[3], 32'hBFC0000C);
    repeat (3) begin
      @(negedge clk);
      chk("halt_read", {31'd0, imem_read}, 32'd0);
    end
    chk("halt_pc", PC, 32'd0);
    chk("halt_valid", {31'd0, InstrValid}, 32'd0);
    RegJumpTarget = 32'd0;
  endtask

  task automatic test_stall_reset();
    int c = 0;
    prog = 2;
    do_reset();
    @(negedge clk);
    while (!(InstrValid && PC == 32'hBFC00024) && c < 60) begin
      @(negedge clk);
      c++;
    end
    chk("stall_reach", PC, 32'hBFC00024);
    Stall = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_instr", Instr, 32'h00851021);
      chk("stall_pc", PC, 32'hBFC00024);
      chk("stall_valid", {31'd0, InstrValid}, 32'd1);
      chk("stall_read", {31'd0, imem_read}, 32'd0);
    end
    rst_n = 1'b0;
    #1;
    chk("stall_rst_pc", PC, 32'hBFC00000);
    Stall = 1'b0;
    @(posedge clk); #1;
    fetched.delete();
    rst_n = 1'b1;
    wait_fetches(3, 20);
    if (fetched.size() >= 3) begin
      chk("post_rst0", fetched[0], 32'hBFC00000);
      chk("post_rst1", fetched[1], 32'hBFC00004);
      chk("post_rst2", fetched[2], 32'hBFC00008);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_waitrequest();
    test_branch();
    test_jump();
    test_halt();
    test_stall_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
